// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: performs SLL/SRL/SRA one bit per clock,
// trading latency for area versus a barrel shifter.
module shift_sequencer #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [SHW-1:0] shamt,
  input  logic [N-1:0]   a,
  input  logic           flush,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [1:0]     r_state;
  logic [N-1:0]   r_shreg;
  logic [SHW-1:0] r_cnt;
  logic [1:0]     r_op;
  logic [N-1:0]   w_shifted;

  // Single-bit step; the reserved encoding falls through to SLL.
  function automatic logic [N-1:0] shift1(input logic [N-1:0] v, input logic [1:0] sel);
    logic signed [N-1:0] sv;
    sv = v;
    case (sel)
      OP_SRL:  shift1 = {1'b0, v[N-1:1]};
      OP_SRA:  shift1 = sv >>> 1;
      default: shift1 = {v[N-2:0], 1'b0};
    endcase
  endfunction

  assign w_shifted = shift1(r_shreg, r_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_op    <= 2'b00;
    end else if (flush) begin
      // Abort keeps the partially shifted value visible on result.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg <= a;
            r_cnt   <= shamt;
            r_op    <= op;
            r_state <= (shamt != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_shreg <= w_shifted;
          r_cnt   <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready  = (r_state == S_IDLE);
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_shreg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with hand-computed results.
module tb_shift_sequencer;
  localparam int N   = 32;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [SHW-1:0] shamt = '0;
  logic [N-1:0]   a = '0;
  logic           flush = 1'b0;
  logic           ready, busy, done;
  logic [N-1:0]   result;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  shift_sequencer #(.N(N), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt),
    .a(a), .flush(flush), .ready(ready), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Start is driven in cycle 0; returns at mid-cycle 1 with operands scrambled.
  task automatic launch(input logic [1:0] o, input logic [N-1:0] v, input logic [SHW-1:0] s);
    start = 1'b1; op = o; a = v; shamt = s;
    @(negedge clk);
    cyc = 1;
    start = 1'b0; op = ~o; a = 32'hA5A5_5A5A; shamt = ~s;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input logic [N-1:0] exp_res);
    while (done !== 1'b1 && cyc < 100) step();
    chk({tag, "_cycle"}, cyc, exp_cyc);
    chk({tag, "_result"}, result, exp_res);
    step();
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
    chk({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    int pulses;
    @(negedge clk);
    chk("rst_ready",  {31'd0, ready}, 32'd1);
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_done",   {31'd0, done},  32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(2'b00, 32'h0000_0001, 5'd4);
    chk("sll4_ready_low", {31'd0, ready}, 32'd0);
    wait_done("sll4", 5, 32'h0000_0010);

    launch(2'b10, 32'h8000_0000, 5'd31);
    wait_done("sra31", 32, 32'hFFFF_FFFF);
    launch(2'b01, 32'h8000_0000, 5'd31);
    wait_done("srl31", 32, 32'h0000_0001);
    launch(2'b10, 32'h7000_0000, 5'd4);
    wait_done("sra_pos", 5, 32'h0700_0000);
    launch(2'b11, 32'h0000_1234, 5'd4);
    wait_done("rsvd_sll", 5, 32'h0001_2340);

    launch(2'b01, 32'hDEAD_BEEF, 5'd0);
    chk("sh0_busy_c1", {31'd0, busy}, 32'd1);
    wait_done("sh0", 1, 32'hDEAD_BEEF);
    chk("sh0_busy_c2", {31'd0, busy}, 32'd0);

    launch(2'b01, 32'hF000_0000, 5'd8);
    while (cyc < 3) step();
    start = 1'b1; a = 32'h1; op = 2'b00; shamt = 5'd1;
    step();
    start = 1'b0;
    wait_done("ign_start", 9, 32'h00F0_0000);

    launch(2'b00, 32'h0000_0001, 5'd10);
    while (cyc < 4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready", {31'd0, ready}, 32'd1);
    chk("flush_result", result, 32'h0000_0008);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    chk("flush_no_done", pulses, 0);

    start = 1'b1; flush = 1'b1; a = 32'h55; op = 2'b00; shamt = 5'd2;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_pri_ready", {31'd0, ready}, 32'd1);
    chk("flush_pri_result", result, 32'h0000_0008);

    launch(2'b01, 32'h0000_0100, 5'd4);
    wait_done("post_flush", 5, 32'h0000_0010);

    launch(2'b00, 32'h0000_0003, 5'd20);
    while (cyc < 5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",  {31'd0, ready}, 32'd1);
    chk("arst_busy",   {31'd0, busy},  32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(2'b00, 32'h0000_0005, 5'd3);
    wait_done("post_rst", 4, 32'h0000_0028);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
